// File: rtl/aplic_msi_notifier.sv
// MSI-mode notifier: picks pending+enabled sources round-robin, fetches their
// target register and issues MSI writes; also serves genmsi software requests.
module aplic_msi_notifier #(
  parameter int NrSources  = 32,
  parameter int NrSourcesW = $clog2(NrSources)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_domaincfg_ie,
  input  logic                  i_domaincfg_dm,
  input  logic [NrSources-1:0]  i_pending,
  input  logic [NrSources-1:0]  i_enabled,
  output logic [NrSourcesW-1:0] o_target_idx,
  input  logic [31:0]           i_target,
  output logic                  o_clrip_valid,
  output logic [NrSourcesW-1:0] o_clrip_idx,
  input  logic                  i_genmsi_we,
  input  logic [31:0]           i_genmsi_wdata,
  output logic                  o_genmsi_busy,
  output logic                  o_msi_valid,
  input  logic                  i_msi_ready,
  output logic [13:0]           o_msi_hart,
  output logic [5:0]            o_msi_gi,
  output logic [10:0]           o_msi_eiid
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, GEN} state_e;

  state_e                state_reg, state_next;
  logic [NrSourcesW-1:0] ptr_reg, ptr_next;
  logic [NrSourcesW-1:0] sel_reg, sel_next;
  logic [NrSourcesW-1:0] target_idx_reg, target_idx_next;
  logic [NrSourcesW-1:0] clrip_idx_reg, clrip_idx_next;
  logic                  clrip_valid_reg, clrip_valid_next;
  logic                  msi_valid_reg, msi_valid_next;
  logic                  busy_reg, busy_next;
  logic [13:0]           hart_reg, hart_next;
  logic [5:0]            gi_reg, gi_next;
  logic [10:0]           eiid_reg, eiid_next;
  logic [13:0]           gen_hi_reg, gen_hi_next;
  logic [10:0]           gen_eiid_reg, gen_eiid_next;

  logic [NrSources-1:0]  pe;
  logic [NrSources-1:0]  pe_hi;
  logic [NrSourcesW-1:0] cand_hi, cand_lo, cand;
  logic [NrSourcesW-1:0] ptr_adv;
  logic                  eligible;
  logic                  unused_bits;

  // Source 0 is reserved and can never become a candidate.
  assign pe       = {i_pending[NrSources-1:1] & i_enabled[NrSources-1:1], 1'b0};
  assign eligible = i_domaincfg_ie & i_domaincfg_dm;
  assign unused_bits = ^{i_pending[0], i_enabled[0], i_target[11], i_genmsi_wdata[17:11]};

  generate
    for (genvar gi = 0; gi < NrSources; gi++) begin : g_pe_hi
      assign pe_hi[gi] = pe[gi] & (NrSourcesW'(gi) >= ptr_reg);
    end
  endgenerate

  // Lowest set index at or above ptr, else lowest set index overall.
  always_comb begin
    cand_hi = '0;
    cand_lo = '0;
    for (int i = NrSources - 1; i > 0; i--) begin
      if (pe_hi[i]) cand_hi = NrSourcesW'(i);
      if (pe[i])    cand_lo = NrSourcesW'(i);
    end
    cand = (|pe_hi) ? cand_hi : cand_lo;
  end

  assign ptr_adv = (sel_reg == NrSourcesW'(NrSources - 1)) ? NrSourcesW'(1)
                                                           : sel_reg + NrSourcesW'(1);

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    sel_next         = sel_reg;
    target_idx_next  = target_idx_reg;
    clrip_idx_next   = clrip_idx_reg;
    clrip_valid_next = 1'b0;
    msi_valid_next   = msi_valid_reg;
    busy_next        = busy_reg;
    hart_next        = hart_reg;
    gi_next          = gi_reg;
    eiid_next        = eiid_reg;
    gen_hi_next      = gen_hi_reg;
    gen_eiid_next    = gen_eiid_reg;

    // Writes while busy (including the cycle busy clears) are dropped.
    if (i_genmsi_we && !busy_reg) begin
      busy_next     = 1'b1;
      gen_hi_next   = i_genmsi_wdata[31:18];
      gen_eiid_next = i_genmsi_wdata[10:0];
    end

    unique case (state_reg)
      IDLE: begin
        if (busy_reg) begin
          state_next     = GEN;
          msi_valid_next = 1'b1;
          hart_next      = gen_hi_reg;
          gi_next        = '0;
          eiid_next      = gen_eiid_reg;
        end else if (eligible && (|pe)) begin
          state_next      = FETCH;
          sel_next        = cand;
          target_idx_next = cand;
        end
      end
      FETCH: begin
        if (!pe[sel_reg] || !eligible) begin
          state_next = IDLE;
        end else if (i_target[10:0] == 11'd0) begin
          state_next       = IDLE;
          clrip_valid_next = 1'b1;
          clrip_idx_next   = sel_reg;
          ptr_next         = ptr_adv;
        end else begin
          state_next     = SEND;
          msi_valid_next = 1'b1;
          hart_next      = i_target[31:18];
          gi_next        = i_target[17:12];
          eiid_next      = i_target[10:0];
        end
      end
      SEND: begin
        if (i_msi_ready) begin
          state_next       = IDLE;
          msi_valid_next   = 1'b0;
          clrip_valid_next = 1'b1;
          clrip_idx_next   = sel_reg;
          ptr_next         = ptr_adv;
        end
      end
      GEN: begin
        if (i_msi_ready) begin
          state_next     = IDLE;
          msi_valid_next = 1'b0;
          busy_next      = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= NrSourcesW'(1);
      sel_reg         <= '0;
      target_idx_reg  <= '0;
      clrip_idx_reg   <= '0;
      clrip_valid_reg <= 1'b0;
      msi_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      hart_reg        <= '0;
      gi_reg          <= '0;
      eiid_reg        <= '0;
      gen_hi_reg      <= '0;
      gen_eiid_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      sel_reg         <= sel_next;
      target_idx_reg  <= target_idx_next;
      clrip_idx_reg   <= clrip_idx_next;
      clrip_valid_reg <= clrip_valid_next;
      msi_valid_reg   <= msi_valid_next;
      busy_reg        <= busy_next;
      hart_reg        <= hart_next;
      gi_reg          <= gi_next;
      eiid_reg        <= eiid_next;
      gen_hi_reg      <= gen_hi_next;
      gen_eiid_reg    <= gen_eiid_next;
    end
  end

  assign o_target_idx  = target_idx_reg;
  assign o_clrip_valid = clrip_valid_reg;
  assign o_clrip_idx   = clrip_idx_reg;
  assign o_genmsi_busy = busy_reg;
  assign o_msi_valid   = msi_valid_reg;
  assign o_msi_hart    = hart_reg;
  assign o_msi_gi      = gi_reg;
  assign o_msi_eiid    = eiid_reg;

endmodule

// File: tb/tb_aplic_msi_notifier.sv
// Directed bench for aplic_msi_notifier; the pending register file is modelled
// by clearing the pending bit whenever a clrip pulse is observed.
module tb_aplic_msi_notifier;
  localparam int N = 32;
  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ie, dm;
  logic [N-1:0]  pending, enabled;
  logic [W-1:0]  target_idx;
  logic [31:0]   target;
  logic          clrip_valid;
  logic [W-1:0]  clrip_idx;
  logic          genmsi_we;
  logic [31:0]   genmsi_wdata;
  logic          genmsi_busy;
  logic          msi_valid, msi_ready;
  logic [13:0]   msi_hart;
  logic [5:0]    msi_gi;
  logic [10:0]   msi_eiid;
  logic [31:0]   tgt_mem [N];

  int vectors = 0;
  int miscompares = 0;

  aplic_msi_notifier #(.NrSources(N), .NrSourcesW(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_domaincfg_ie(ie), .i_domaincfg_dm(dm),
    .i_pending(pending), .i_enabled(enabled),
    .o_target_idx(target_idx), .i_target(target),
    .o_clrip_valid(clrip_valid), .o_clrip_idx(clrip_idx),
    .i_genmsi_we(genmsi_we), .i_genmsi_wdata(genmsi_wdata),
    .o_genmsi_busy(genmsi_busy),
    .o_msi_valid(msi_valid), .i_msi_ready(msi_ready),
    .o_msi_hart(msi_hart), .o_msi_gi(msi_gi), .o_msi_eiid(msi_eiid)
  );

  assign target = tgt_mem[target_idx];

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_tgt(input logic [13:0] hi, input logic [5:0] g,
                                         input logic [10:0] e);
    return {hi, g, 1'b0, e};
  endfunction

  // One clock; sample 1 time unit after the edge and apply any pending clear.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clrip_valid) pending[clrip_idx] = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 99;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (msi_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({msi_valid, clrip_valid, genmsi_busy, target_idx, clrip_idx, msi_hart, msi_gi, msi_eiid} !== '0) begin
      $display("FAIL reset_outputs: got v=%0b c=%0b b=%0b t=%0d h=%0d e=%0d want all 0",
               msi_valid, clrip_valid, genmsi_busy, target_idx, msi_hart, msi_eiid);
      miscompares++;
    end
  endtask

  task automatic test_basic();
    int n;
    int seen;
    enabled = '1; ie = 1'b1; dm = 1'b1; msi_ready = 1'b1;
    tgt_mem[3] = mk_tgt(14'd2, 6'd1, 11'd7);
    tgt_mem[5] = mk_tgt(14'd4, 6'd2, 11'd9);
    pending[0] = 1'b1; pending[3] = 1'b1; pending[5] = 1'b1;
    wait_valid(n);
    vectors++; if (n != 2) begin $display("FAIL basic_latency: got %0d want 2", n); miscompares++; end
    vectors++; if (target_idx !== 5'd3) begin $display("FAIL basic_tidx: got %0d want 3", target_idx); miscompares++; end
    vectors++; if ({msi_hart, msi_gi, msi_eiid} !== {14'd2, 6'd1, 11'd7}) begin
      $display("FAIL basic_msi0: got %0d/%0d/%0d want 2/1/7", msi_hart, msi_gi, msi_eiid); miscompares++; end
    tick();
    vectors++; if ({msi_valid, clrip_valid, clrip_idx} !== {1'b0, 1'b1, 5'd3}) begin
      $display("FAIL basic_clr0: got v=%0b c=%0b idx=%0d want 0/1/3", msi_valid, clrip_valid, clrip_idx); miscompares++; end
    wait_valid(n);
    vectors++; if (n != 2) begin $display("FAIL basic_throughput: got %0d want 2", n); miscompares++; end
    vectors++; if ({msi_hart, msi_gi, msi_eiid} !== {14'd4, 6'd2, 11'd9}) begin
      $display("FAIL basic_msi1: got %0d/%0d/%0d want 4/2/9", msi_hart, msi_gi, msi_eiid); miscompares++; end
    tick();
    vectors++; if ({clrip_valid, clrip_idx} !== {1'b1, 5'd5}) begin
      $display("FAIL basic_clr1: got c=%0b idx=%0d want 1/5", clrip_valid, clrip_idx); miscompares++; end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (msi_valid || clrip_valid) seen++;
    end
    vectors++; if (seen != 0) begin $display("FAIL basic_src0_idle: got %0d active cycles want 0", seen); miscompares++; end
    pending[0] = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    tgt_mem[2]  = mk_tgt(14'd10, 6'd0, 11'd20);
    tgt_mem[6]  = mk_tgt(14'd12, 6'd3, 11'd21);
    tgt_mem[31] = mk_tgt(14'd31, 6'd4, 11'd31);
    tgt_mem[1]  = mk_tgt(14'd1, 6'd0, 11'd1);
    tgt_mem[30] = mk_tgt(14'd30, 6'd0, 11'd30);
    pending[2] = 1'b1; pending[6] = 1'b1;
    wait_valid(n);
    vectors++; if ({target_idx, msi_eiid} !== {5'd6, 11'd21}) begin
      $display("FAIL rr_first: got idx=%0d eiid=%0d want 6/21", target_idx, msi_eiid); miscompares++; end
    tick();
    wait_valid(n);
    vectors++; if ({target_idx, msi_eiid} !== {5'd2, 11'd20}) begin
      $display("FAIL rr_second: got idx=%0d eiid=%0d want 2/20", target_idx, msi_eiid); miscompares++; end
    tick();
    pending[31] = 1'b1;
    wait_valid(n);
    vectors++; if ({msi_hart, msi_gi, msi_eiid} !== {14'd31, 6'd4, 11'd31}) begin
      $display("FAIL rr_top: got %0d/%0d/%0d want 31/4/31", msi_hart, msi_gi, msi_eiid); miscompares++; end
    tick();
    vectors++; if ({clrip_valid, clrip_idx} !== {1'b1, 5'd31}) begin
      $display("FAIL rr_top_clr: got c=%0b idx=%0d want 1/31", clrip_valid, clrip_idx); miscompares++; end
    pending[1] = 1'b1; pending[30] = 1'b1;
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd1) begin $display("FAIL rr_wrap_first: got %0d want 1", msi_eiid); miscompares++; end
    tick();
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd30) begin $display("FAIL rr_wrap_second: got %0d want 30", msi_eiid); miscompares++; end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    msi_ready = 1'b0;
    tgt_mem[4] = mk_tgt(14'd100, 6'd5, 11'd300);
    pending[4] = 1'b1;
    wait_valid(n);
    vectors++; if (n != 2) begin $display("FAIL bp_latency: got %0d want 2", n); miscompares++; end
    for (int c = 1; c <= 5; c++) begin
      tick();
      vectors++;
      if ({msi_valid, msi_hart, msi_gi, msi_eiid} !== {1'b1, 14'd100, 6'd5, 11'd300}) begin
        $display("FAIL bp_hold_%0d: got v=%0b %0d/%0d/%0d want 1 100/5/300", c, msi_valid, msi_hart, msi_gi, msi_eiid);
        miscompares++;
      end
      if (c == 2) begin ie = 1'b0; pending[4] = 1'b0; end
    end
    msi_ready = 1'b1;
    tick();
    vectors++; if ({msi_valid, clrip_valid, clrip_idx} !== {1'b0, 1'b1, 5'd4}) begin
      $display("FAIL bp_handshake: got v=%0b c=%0b idx=%0d want 0/1/4", msi_valid, clrip_valid, clrip_idx); miscompares++; end
    ie = 1'b1;
    tick();
  endtask

  task automatic test_genmsi();
    int n;
    msi_ready = 1'b0;
    genmsi_wdata = {14'd1, 7'd0, 11'd33};
    genmsi_we = 1'b1;
    tick();
    genmsi_we = 1'b0;
    pending[4] = 1'b1;
    vectors++; if ({genmsi_busy, msi_valid} !== 2'b10) begin
      $display("FAIL gen_busy_set: got busy=%0b v=%0b want 1/0", genmsi_busy, msi_valid); miscompares++; end
    tick();
    vectors++; if ({msi_valid, msi_hart, msi_gi, msi_eiid} !== {1'b1, 14'd1, 6'd0, 11'd33}) begin
      $display("FAIL gen_msi: got v=%0b %0d/%0d/%0d want 1 1/0/33", msi_valid, msi_hart, msi_gi, msi_eiid); miscompares++; end
    genmsi_wdata = {14'd7, 7'd0, 11'd44};
    genmsi_we = 1'b1;
    tick();
    genmsi_we = 1'b0;
    vectors++; if ({genmsi_busy, msi_valid, msi_hart, msi_eiid} !== {1'b1, 1'b1, 14'd1, 11'd33}) begin
      $display("FAIL gen_write_ignored: got busy=%0b v=%0b %0d/%0d want 1 1 1/33", genmsi_busy, msi_valid, msi_hart, msi_eiid);
      miscompares++; end
    msi_ready = 1'b1;
    genmsi_wdata = {14'd9, 7'd0, 11'd55};
    genmsi_we = 1'b1;
    tick();
    genmsi_we = 1'b0;
    vectors++; if ({msi_valid, genmsi_busy, clrip_valid} !== 3'b000) begin
      $display("FAIL gen_done: got v=%0b busy=%0b c=%0b want 0/0/0", msi_valid, genmsi_busy, clrip_valid); miscompares++; end
    wait_valid(n);
    vectors++; if ({n == 2, msi_hart, msi_eiid} !== {1'b1, 14'd100, 11'd300}) begin
      $display("FAIL gen_then_src4: got n=%0d %0d/%0d want 2 100/300", n, msi_hart, msi_eiid); miscompares++; end
    tick();
    vectors++; if ({clrip_valid, clrip_idx, genmsi_busy} !== {1'b1, 5'd4, 1'b0}) begin
      $display("FAIL gen_src4_clr: got c=%0b idx=%0d busy=%0b want 1/4/0", clrip_valid, clrip_idx, genmsi_busy); miscompares++; end
    tick();
  endtask

  task automatic test_genmsi_zero();
    dm = 1'b0;
    genmsi_wdata = {14'd3, 7'd0, 11'd0};
    genmsi_we = 1'b1;
    tick();
    genmsi_we = 1'b0;
    tick();
    vectors++; if ({msi_valid, msi_hart, msi_gi, msi_eiid} !== {1'b1, 14'd3, 6'd0, 11'd0}) begin
      $display("FAIL gen_zero: got v=%0b %0d/%0d/%0d want 1 3/0/0", msi_valid, msi_hart, msi_gi, msi_eiid); miscompares++; end
    tick();
    vectors++; if ({msi_valid, genmsi_busy} !== 2'b00) begin
      $display("FAIL gen_zero_done: got v=%0b busy=%0b want 0/0", msi_valid, genmsi_busy); miscompares++; end
    dm = 1'b1;
  endtask

  task automatic test_skip_abort();
    int n;
    tgt_mem[8] = mk_tgt(14'd5, 6'd0, 11'd0);
    tgt_mem[9] = mk_tgt(14'd6, 6'd0, 11'd66);
    pending[8] = 1'b1;
    tick();
    vectors++; if ({target_idx, msi_valid} !== {5'd8, 1'b0}) begin
      $display("FAIL skip_select: got idx=%0d v=%0b want 8/0", target_idx, msi_valid); miscompares++; end
    tick();
    vectors++; if ({msi_valid, clrip_valid, clrip_idx} !== {1'b0, 1'b1, 5'd8}) begin
      $display("FAIL skip_clr: got v=%0b c=%0b idx=%0d want 0/1/8", msi_valid, clrip_valid, clrip_idx); miscompares++; end
    tick();
    vectors++; if ({msi_valid, clrip_valid} !== 2'b00) begin
      $display("FAIL skip_pulse_len: got v=%0b c=%0b want 0/0", msi_valid, clrip_valid); miscompares++; end
    pending[9] = 1'b1;
    tick();
    vectors++; if (target_idx !== 5'd9) begin $display("FAIL abort_select: got %0d want 9", target_idx); miscompares++; end
    pending[9] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++; if ({msi_valid, clrip_valid} !== 2'b00) begin
        $display("FAIL abort_quiet_%0d: got v=%0b c=%0b want 0/0", c, msi_valid, clrip_valid); miscompares++; end
    end
    pending[9] = 1'b1; pending[3] = 1'b1;
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd66) begin $display("FAIL abort_ptr_kept: got %0d want 66", msi_eiid); miscompares++; end
    tick();
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd7) begin $display("FAIL abort_next: got %0d want 7", msi_eiid); miscompares++; end
    tick();
  endtask

  task automatic test_reset_mid_send();
    int n;
    msi_ready = 1'b0;
    tgt_mem[12] = mk_tgt(14'd12, 6'd1, 11'd120);
    tgt_mem[20] = mk_tgt(14'd20, 6'd0, 11'd200);
    pending[12] = 1'b1;
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd120) begin $display("FAIL rst_pre_send: got %0d want 120", msi_eiid); miscompares++; end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({msi_valid, clrip_valid, genmsi_busy, target_idx, clrip_idx, msi_hart, msi_gi, msi_eiid} !== '0) begin
      $display("FAIL rst_async: got v=%0b c=%0b t=%0d h=%0d e=%0d want all 0", msi_valid, clrip_valid, target_idx, msi_hart, msi_eiid);
      miscompares++;
    end
    pending[12] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    msi_ready = 1'b1;
    tick();
    vectors++; if ({msi_valid, clrip_valid} !== 2'b00) begin
      $display("FAIL rst_release_idle: got v=%0b c=%0b want 0/0", msi_valid, clrip_valid); miscompares++; end
    pending[2] = 1'b1; pending[20] = 1'b1;
    wait_valid(n);
    vectors++; if ({n == 2, msi_eiid} !== {1'b1, 11'd20}) begin
      $display("FAIL rst_ptr_one: got n=%0d eiid=%0d want 2/20", n, msi_eiid); miscompares++; end
    tick();
    wait_valid(n);
    vectors++; if (msi_eiid !== 11'd200) begin $display("FAIL rst_second: got %0d want 200", msi_eiid); miscompares++; end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ie = 1'b0; dm = 1'b0;
    pending = '0; enabled = '0;
    genmsi_we = 1'b0; genmsi_wdata = '0;
    msi_ready = 1'b0;
    for (int i = 0; i < N; i++) tgt_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_genmsi();
    test_genmsi_zero();
    test_skip_abort();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aplic_msi_notifier.md
# aplic_msi_notifier

Downstream stage of the APLIC register file for domains in MSI delivery mode. Selects pending-and-enabled interrupt sources round-robin, fetches each one's `target` register, and issues an MSI request (hart index, guest index, EIID) to the bus-write adapter. It also services `genmsi` software requests and clears the source pending bit once the MSI is accepted.

## Interface
- `NrSources`, 32: number of source slots; source 0 is reserved and never selected.
- `NrSourcesW`, `$clog2(NrSources)`: source index width.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_domaincfg_ie`  in  1  domain interrupt enable.
- `i_domaincfg_dm`  in  1  delivery mode; 1 = MSI. The block is idle when 0.
- `i_pending`  in  NrSources  pending bitmap.
- `i_enabled`  in  NrSources  enable bitmap.
- `o_target_idx`  out  NrSourcesW  target register read index.
- `i_target`  in  32  target register data, valid the cycle after `o_target_idx` changes. Fields: hi [31:18], gi [17:12], eiid [10:0].
- `o_clrip_valid`  out  1  one-cycle pulse that clears the pending bit of `o_clrip_idx`.
- `o_clrip_idx`  out  NrSourcesW  source whose pending bit is cleared.
- `i_genmsi_we`  in  1  write strobe for `genmsi`.
- `i_genmsi_wdata`  in  32  hi [31:18], eiid [10:0].
- `o_genmsi_busy`  out  1  reflects `genmsi.busy`.
- `o_msi_valid`  out  1  MSI request valid.
- `i_msi_ready`  in  1  MSI request accepted.
- `o_msi_hart`  out  14  hart index.
- `o_msi_gi`  out  6  guest index.
- `o_msi_eiid`  out  11  external interrupt identity.

## Operation
- Candidate vector: `pe = i_pending & i_enabled`, with bit 0 forced to 0. A source is eligible only when `i_domaincfg_ie & i_domaincfg_dm`.
- Selection: the lowest set index in `pe` that is ≥ `ptr`. If none exists, the lowest set index overall.
  - `ptr` reset value is 1.
  - After any source completes (sent or skipped), `ptr` becomes selected+1; it wraps from NrSources to 1.
- States: IDLE, FETCH, SEND, GEN.
- IDLE:
  - If `busy` is set, go to GEN. `genmsi` has priority over sources.
  - Else, if the source is eligible and any `pe` bit is set, register the selected index into `o_target_idx` and the internal `sel`, then go to FETCH.
- FETCH:
  - Abort to IDLE if `pe[sel]` is now 0, `ie` is 0, or `dm` is 0. `ptr` is unchanged; nothing is sent or cleared.
  - If `i_target` eiid == 0: pulse `o_clrip` for `sel`, update `ptr`, go to IDLE. No MSI is sent.
  - Otherwise latch hi/gi/eiid into the `o_msi_*` registers, assert `o_msi_valid`, and go to SEND.
- SEND:
  - Hold `o_msi_valid` and all fields stable until `i_msi_ready`. Valid is never retracted, even if pending, `ie` or `dm` drop.
  - On handshake: deassert valid, pulse `o_clrip` for `sel`, update `ptr`, go to IDLE.
- GEN:
  - Drive `o_msi_valid` with hi = latched hi, gi = 0, eiid = latched eiid. eiid 0 is sent as-is.
  - On handshake: clear `busy`, go to IDLE. `ptr` is unchanged.
  - GEN is independent of `ie` and `dm`.
- `genmsi` write:
  - `i_genmsi_we` while `busy` == 0 latches hi/eiid and sets `busy`.
  - Writes while `busy` == 1 are ignored.
  - A write arriving in the same cycle `busy` clears is ignored.
- Reset values: all outputs 0, `busy` 0, state IDLE, `ptr` 1.

## Timing
- Candidate sampled at clock edge k (IDLE): `o_target_idx` is valid after k, and `i_target` is sampled at k+1.
  - After k+1, `o_msi_valid` is 1, so latency from an eligible pending bit to request is 2 cycles.
- Handshake at edge h: after h, `o_msi_valid` is 0 and `o_clrip_valid` is 1 for exactly one cycle.
  - The next selection happens at h+1. Back-to-back throughput is one MSI per 3 cycles with `i_msi_ready` tied high.
- The `o_clrip` pulse for an eiid-0 skip follows the FETCH edge by one cycle.
- `genmsi` write at edge w: `o_genmsi_busy` is 1 after w. From IDLE, `o_msi_valid` is 1 after w+1.
- Asynchronous reset mid-SEND drops `o_msi_valid` immediately; no clear is issued.

## Test plan
- Sources 3 and 5 pending+enabled, ie=dm=1, `i_msi_ready`=1, targets hi=2/eiid=7 and hi=4/eiid=9 -> MSI (2,gi,7) then (4,gi,9) in that order; `o_clrip_idx` 3 then 5; first valid 2 cycles after pending.
- Round-robin: `ptr`=6, sources 2 and 6 pending -> 6 served first, then 2; `ptr` wraps to 1 after serving NrSources-1.
- Backpressure: `i_msi_ready` low for 5 cycles with pending and `ie` dropped meanwhile -> valid and fields stable 5 cycles, then handshake and clear.
- `genmsi` write hi=1/eiid=33 while source 4 pending -> `genmsi` MSI (1,0,33) first and `busy` clears; a second write during busy is ignored; then source 4 is sent.
- Source 8 target eiid=0 -> no `o_msi_valid`, `o_clrip` pulse for 8. Pending cleared externally during FETCH -> abort, no clear pulse.
- Reset asserted during SEND -> all outputs 0 asynchronously; `ptr`=1 and IDLE after release.
